aud_recorder: RTL and testbench
===============================

Name: aud_recorder

Overview:
- Capture side of the audio path: deserializes the left channel of the codec's I2S ADC stream and writes one 16-bit sample per frame into SRAM at consecutive addresses.
- Sits between the I2S pins and the SRAM arbiter, mirroring the playback DSP.
- Its end address is the playback block's end-address input.
- Supports start / pause / stop and stops automatically when memory is full.

Parameters:
- DATA_W, 16, sample width in bits (MSB-first on the serial line).
- ADDR_W, 20, SRAM word-address width.
- MAX_ADDR, 20'hFFFFF, last writable address; recording stops after writing it.

Ports:
- i_clk  input  1  system clock; must be ≥4× BCLK frequency.
- i_rst_n  input  1  asynchronous active-low reset.
- i_start  input  1  level; begin recording from address 0 (accepted in IDLE only).
- i_pause  input  1  level; hold capture while high.
- i_stop  input  1  level; abort to IDLE, keep o_end_addr.
- i_aud_bclk  input  1  I2S bit clock (asynchronous).
- i_aud_adclrck  input  1  I2S word clock; 0 = left channel.
- i_aud_adcdat  input  1  I2S serial data.
- o_sram_addr  output ADDR_W  write address.
- o_sram_data  output DATA_W  write data.
- o_sram_we  output  1  one-cycle write strobe, active high.
- o_end_addr  output ADDR_W  number of samples written (next free address).
- o_recording  output  1  high in WAIT, SHIFT and WRITE.
- o_full  output  1  sticky; set when MAX_ADDR written, cleared on next accepted start.

Behaviour:
- Clock and reset: one clock i_clk; reset is asynchronous and active-low, i_rst_n.
- Reset values: all outputs 0; state IDLE; bit counter 0; shift register 0.
- Synchronization: bclk, adclrck and adcdat each pass through a 2-flop synchronizer.
- Edge events: bclk rising edge = synced bclk 1 and previous bclk 0. lrck falling edge is detected on a bclk rising edge where the sampled lrck is 0 and the previously sampled lrck was 1.
- IDLE: o_sram_addr is held at 0. On i_start → WAIT, clear addr, o_end_addr and o_full. i_pause and i_stop are ignored.
- WAIT: on an lrck falling edge → SHIFT with bit count 0. The first bclk rise after the lrck edge is the I2S one-bit delay and is skipped.
- SHIFT: on each following bclk rise, shift adcdat into the LSB (MSB first) and increment the count. After DATA_W bits → WRITE.
  - If lrck rises before DATA_W bits, discard the partial word and return to WAIT.
- WRITE (exactly 1 cycle):
  - o_sram_we=1, o_sram_data=shift register, o_sram_addr=current addr.
  - Next cycle: o_end_addr = addr+1.
  - If addr==MAX_ADDR → IDLE with o_full=1; else addr+1 → WAIT.
- Write latency: the strobe occurs 1 i_clk cycle after the bclk rise that captured the LSB. Data and addr are stable during the strobe.
- Pause:
  - i_pause in WAIT or SHIFT → PAUSE; any partial word is discarded.
  - In WRITE, the write completes first and the pause takes effect next cycle.
  - PAUSE → WAIT when i_pause falls. addr is preserved.
- Stop: i_stop in any non-IDLE state → IDLE. Stop has priority over pause. A write in progress (WRITE state) still completes. o_end_addr is retained.
- Simultaneous start and stop in IDLE: the start is taken.
- Wrap-around: addr never wraps; full stops recording instead.
- Reset mid-operation: immediate return to IDLE; any pending write is dropped.

Optional Feature:
- Macro AUD_REC_PEAK_EN.
- When defined: adds output o_peak[DATA_W-1:0], the maximum absolute value of the written signed samples since the last accepted start.
  - |−32768| saturates to 16'h7FFF.
  - Updated in the same cycle as o_sram_we; registered.
  - Reset to 0; cleared on start.
- When undefined: no port, no logic.

Test Plan:
- Reset, then start; send 3 left words 16'h1234, 16'hABCD, 16'h0001 → strobes at addr 0, 1, 2 with matching data; o_end_addr=3.
- Right-channel data 16'hFFFF interleaved with left 16'h0000 → only 16'h0000 is written; one write per frame.
- Pause asserted mid-word (after bit 7), released 2 frames later → partial word not written; the next full word lands at the next address, no gap.
- Stop during SHIFT after 5 written words → no further strobes, o_end_addr=5, o_recording=0. A new start clears o_end_addr to 0.
- MAX_ADDR=3 build, record 6 frames → exactly 4 writes (addr 0–3), o_full=1, state IDLE.
- AUD_REC_PEAK_EN build: samples 16'h0100, 16'hF000, 16'h8000 → o_peak 16'h0100, 16'h1000, 16'h7FFF.

Source files
------------

// File: rtl/aud_recorder.sv
// I2S ADC capture: left-channel samples are written to consecutive SRAM words.
// Define AUD_REC_PEAK_EN to add the o_peak absolute-peak tracker.
module aud_recorder #(
    parameter int unsigned         DATA_W   = 16,
    parameter int unsigned         ADDR_W   = 20,
    parameter logic [ADDR_W-1:0]   MAX_ADDR = ADDR_W'(20'hFFFFF)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_aud_bclk,
    input  logic              i_aud_adclrck,
    input  logic              i_aud_adcdat,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_data,
    output logic              o_sram_we,
    output logic [ADDR_W-1:0] o_end_addr,
    output logic              o_recording,
    output logic              o_full
`ifdef AUD_REC_PEAK_EN
    ,
    output logic [DATA_W-1:0] o_peak
`endif
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_SHIFT = 3'd2,
        S_WRITE = 3'd3,
        S_PAUSE = 3'd4
    } state_t;

    state_t             state, state_d;
    logic [1:0]         bclk_sync, lrck_sync, dat_sync;
    logic               bclk_prev, lrck_prev;
    logic               bclk_rise, lrck_fall, lrck_rise;
    logic [ADDR_W-1:0]  addr, addr_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               we_d, full_d;
    logic [DATA_W-1:0]  data_d;
    logic [ADDR_W-1:0]  end_d;
`ifdef AUD_REC_PEAK_EN
    logic [DATA_W-1:0]  peak_d, mag;
`endif

    // Edge events; lrck is only examined on bclk rises so both edges are bit-aligned.
    assign bclk_rise = bclk_sync[1] & ~bclk_prev;
    assign lrck_fall = bclk_rise & ~lrck_sync[1] & lrck_prev;
    assign lrck_rise = bclk_rise & lrck_sync[1] & ~lrck_prev;

    // Synchronizers and previous-sample registers for the asynchronous I2S pins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            dat_sync  <= '0;
            bclk_prev <= 1'b0;
            lrck_prev <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[0], i_aud_bclk};
            lrck_sync <= {lrck_sync[0], i_aud_adclrck};
            dat_sync  <= {dat_sync[0], i_aud_adcdat};
            bclk_prev <= bclk_sync[1];
            if (bclk_rise) begin
                lrck_prev <= lrck_sync[1];
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state;
        addr_d  = addr;
        shift_d = shift_q;
        cnt_d   = cnt;
        we_d    = 1'b0;
        data_d  = o_sram_data;
        end_d   = o_end_addr;
        full_d  = o_full;
`ifdef AUD_REC_PEAK_EN
        peak_d  = o_peak;
        mag     = '0;
`endif
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_WAIT;
                    addr_d  = '0;
                    end_d   = '0;
                    full_d  = 1'b0;
`ifdef AUD_REC_PEAK_EN
                    peak_d  = '0;
`endif
                end
            end
            S_WAIT: begin
                if (i_stop) begin
                    state_d = S_IDLE;
                end else if (i_pause) begin
                    state_d = S_PAUSE;
                end else if (lrck_fall) begin
                    // The detecting bclk rise is the I2S one-bit delay slot.
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                end
            end
            S_SHIFT: begin
                if (i_stop) begin
                    state_d = S_IDLE;
                end else if (i_pause) begin
                    state_d = S_PAUSE;
                end else if (lrck_rise) begin
                    state_d = S_WAIT;
                end else if (bclk_rise) begin
                    shift_d = {shift_q[DATA_W-2:0], dat_sync[1]};
                    cnt_d   = cnt + 1'b1;
                    if (cnt_d == CNT_W'(DATA_W)) begin
                        state_d = S_WRITE;
                        we_d    = 1'b1;
                        data_d  = shift_d;
`ifdef AUD_REC_PEAK_EN
                        if (shift_d[DATA_W-1]) begin
                            mag = (shift_d == {1'b1, {(DATA_W-1){1'b0}}}) ?
                                  {1'b0, {(DATA_W-1){1'b1}}} : DATA_W'(~shift_d + 1'b1);
                        end else begin
                            mag = shift_d;
                        end
                        if (mag > o_peak) begin
                            peak_d = mag;
                        end
`endif
                    end
                end
            end
            S_WRITE: begin
                end_d = addr + 1'b1;
                if (addr == MAX_ADDR) begin
                    state_d = S_IDLE;
                    full_d  = 1'b1;
                end else begin
                    addr_d = addr + 1'b1;
                    if (i_stop) begin
                        state_d = S_IDLE;
                    end else if (i_pause) begin
                        state_d = S_PAUSE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_PAUSE: begin
                if (i_stop) begin
                    state_d = S_IDLE;
                end else if (!i_pause) begin
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            addr        <= '0;
            shift_q     <= '0;
            cnt         <= '0;
            o_sram_addr <= '0;
            o_sram_data <= '0;
            o_sram_we   <= 1'b0;
            o_end_addr  <= '0;
            o_recording <= 1'b0;
            o_full      <= 1'b0;
`ifdef AUD_REC_PEAK_EN
            o_peak      <= '0;
`endif
        end else begin
            state       <= state_d;
            addr        <= addr_d;
            shift_q     <= shift_d;
            cnt         <= cnt_d;
            o_sram_addr <= (state_d == S_IDLE) ? '0 : addr_d;
            o_sram_data <= data_d;
            o_sram_we   <= we_d;
            o_end_addr  <= end_d;
            o_recording <= (state_d == S_WAIT) || (state_d == S_SHIFT) || (state_d == S_WRITE);
            o_full      <= full_d;
`ifdef AUD_REC_PEAK_EN
            o_peak      <= peak_d;
`endif
        end
    end

endmodule

// File: tb/tb_aud_recorder.sv
// Self-checking bench for aud_recorder: drives I2S frames and compares SRAM writes
// against a frame-level model of which left words should land where.
module tb_aud_recorder;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 20;
    localparam logic [ADDR_W-1:0] MAX_A = 20'd7;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0, pause = 1'b0, stop = 1'b0;
    logic              bclk = 1'b0, lrck = 1'b1, dat = 1'b0;
    logic [ADDR_W-1:0] sram_addr, end_addr;
    logic [DATA_W-1:0] sram_data;
    logic              sram_we, recording, full;
`ifdef AUD_REC_PEAK_EN
    logic [DATA_W-1:0] peak;
`endif

    int  checks = 0;
    int  errors = 0;
    wr_t exp_q[$];
    wr_t obs_q[$];
    int  we_run = 0;
    int  we_long = 0;

    // Frame-level reference model state
    bit                m_active = 1'b0;
    bit                m_full = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0;
    int                m_end = 0;
    int                m_peak = 0;

    aud_recorder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_ADDR(MAX_A)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_pause       (pause),
        .i_stop        (stop),
        .i_aud_bclk    (bclk),
        .i_aud_adclrck (lrck),
        .i_aud_adcdat  (dat),
        .o_sram_addr   (sram_addr),
        .o_sram_data   (sram_data),
        .o_sram_we     (sram_we),
        .o_end_addr    (end_addr),
        .o_recording   (recording),
`ifdef AUD_REC_PEAK_EN
        .o_peak        (peak),
`endif
        .o_full        (full)
    );

    always #5 clk = ~clk;

    // Capture every write strobe and flag strobes longer than one cycle.
    always @(negedge clk) begin
        if (sram_we) begin
            obs_q.push_back(wr_t'({sram_addr, sram_data}));
            we_run++;
            if (we_run > 1) we_long++;
        end else begin
            we_run = 0;
        end
    end

    task automatic idle_bclk(input int n);
        for (int i = 0; i < n; i++) begin
            bclk = 1'b0; lrck = 1'b1; dat = 1'b0;
            #40 bclk = 1'b1;
            #40;
        end
    endtask

    // One I2S frame: 20 bclks left (lrck=0), 20 right. Slot 0 of each half is the
    // one-bit delay, slots 1..16 carry the word MSB first. Control actions fire at
    // the bclk falling edge of the given absolute slot (-1 = never).
    task automatic send_frame(input logic [15:0] l, input logic [15:0] r,
                              input int p_on, input int p_off, input int s_on);
        bit clean;
        int v, a;
        logic [15:0] w;
        clean = m_active && !pause && !(p_on >= 0 && p_on <= 16) && !(s_on >= 0 && s_on <= 16);
        if (clean) begin
            exp_q.push_back(wr_t'({m_addr, l}));
            v = int'($signed(l));
            a = (v < 0) ? -v : v;
            if (a > 32767) a = 32767;
            if (a > m_peak) m_peak = a;
            m_end = int'(m_addr) + 1;
            if (m_addr == MAX_A) begin
                m_active = 1'b0;
                m_full   = 1'b1;
            end else begin
                m_addr = m_addr + 1'b1;
            end
        end
        if (s_on >= 0) m_active = 1'b0;
        for (int slot = 0; slot < 40; slot++) begin
            int s;
            s = slot % 20;
            w = (slot < 20) ? l : r;
            bclk = 1'b0;
            lrck = (slot >= 20);
            dat  = (s >= 1 && s <= 16) ? w[16-s] : 1'($urandom);
            if (slot == p_on)  pause = 1'b1;
            if (slot == p_off) pause = 1'b0;
            if (slot == s_on)  stop  = 1'b1;
            #40 bclk = 1'b1;
            #40;
        end
        stop = 1'b0;
    endtask

    task automatic do_start();
        obs_q.delete();
        exp_q.delete();
        we_long = 0;
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        m_active = 1'b1; m_full = 1'b0; m_addr = '0; m_end = 0; m_peak = 0;
    endtask

    task automatic do_stop();
        @(posedge clk); #2 stop = 1'b1;
        repeat (2) @(posedge clk);
        #2 stop = 1'b0;
        m_active = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if ({sram_we, recording, full} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b expected 000", {sram_we, recording, full});
        end
        checks++;
        if (sram_addr !== '0 || end_addr !== '0 || sram_data !== '0) begin
            errors++; $display("FAIL reset_values: got addr=%h end=%h data=%h expected 0", sram_addr, end_addr, sram_data);
        end
`ifdef AUD_REC_PEAK_EN
        checks++;
        if (peak !== '0) begin
            errors++; $display("FAIL reset_peak: got %h expected 0", peak);
        end
`endif
        rst_n = 1'b1;
        idle_bclk(4);
    endtask

    task automatic test_basic();
        do_start();
        send_frame(16'h1234, 16'($urandom), -1, -1, -1);
        send_frame(16'hABCD, 16'($urandom), -1, -1, -1);
        send_frame(16'h0001, 16'($urandom), -1, -1, -1);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL basic_count: got %0d writes expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL basic_write%0d: got %h/%h expected %h/%h", i, obs_q[i].addr, obs_q[i].data, exp_q[i].addr, exp_q[i].data);
            end
        end
        checks++;
        if (end_addr !== ADDR_W'(m_end) || recording !== 1'b1 || we_long != 0) begin
            errors++; $display("FAIL basic_status: got end=%0d rec=%b long=%0d expected end=%0d rec=1 long=0", end_addr, recording, we_long, m_end);
        end
        do_stop();
    endtask

    task automatic test_right_channel();
        do_start();
        for (int i = 0; i < 3; i++) send_frame(16'h0000, 16'hFFFF, -1, -1, -1);
        for (int i = 0; i < 2; i++) send_frame(16'($urandom), 16'($urandom), -1, -1, -1);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL right_count: got %0d writes expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL right_write%0d: got %h/%h expected %h/%h", i, obs_q[i].addr, obs_q[i].data, exp_q[i].addr, exp_q[i].data);
            end
        end
        do_stop();
    endtask

    task automatic test_pause();
        do_start();
        send_frame(16'($urandom), 16'($urandom), -1, -1, -1);
        send_frame(16'($urandom), 16'($urandom),  9, -1, -1);
        send_frame(16'($urandom), 16'($urandom), -1, -1, -1);
        send_frame(16'($urandom), 16'($urandom), -1, 30, -1);
        send_frame(16'($urandom), 16'($urandom), -1, -1, -1);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL pause_count: got %0d writes expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL pause_write%0d: got %h/%h expected %h/%h", i, obs_q[i].addr, obs_q[i].data, exp_q[i].addr, exp_q[i].data);
            end
        end
        checks++;
        if (end_addr !== ADDR_W'(m_end)) begin
            errors++; $display("FAIL pause_end: got %0d expected %0d", end_addr, m_end);
        end
        do_stop();
    endtask

    task automatic test_stop();
        do_start();
        for (int i = 0; i < 5; i++) send_frame(16'($urandom), 16'($urandom), -1, -1, -1);
        send_frame(16'($urandom), 16'($urandom), -1, -1, 10);
        send_frame(16'($urandom), 16'($urandom), -1, -1, -1);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL stop_count: got %0d writes expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL stop_write%0d: got %h/%h expected %h/%h", i, obs_q[i].addr, obs_q[i].data, exp_q[i].addr, exp_q[i].data);
            end
        end
        checks++;
        if (end_addr !== ADDR_W'(m_end) || recording !== 1'b0 || sram_addr !== '0) begin
            errors++; $display("FAIL stop_status: got end=%0d rec=%b addr=%h expected end=%0d rec=0 addr=0", end_addr, recording, sram_addr, m_end);
        end
        do_start();
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (end_addr !== '0 || recording !== 1'b1) begin
            errors++; $display("FAIL restart_clear: got end=%0d rec=%b expected end=0 rec=1", end_addr, recording);
        end
        do_stop();
    endtask

    task automatic test_full();
        do_start();
        for (int i = 0; i < 10; i++) send_frame(16'($urandom), 16'($urandom), -1, -1, -1);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL full_count: got %0d writes expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL full_write%0d: got %h/%h expected %h/%h", i, obs_q[i].addr, obs_q[i].data, exp_q[i].addr, exp_q[i].data);
            end
        end
        checks++;
        if (full !== m_full || recording !== 1'b0 || end_addr !== ADDR_W'(m_end)) begin
            errors++; $display("FAIL full_status: got full=%b rec=%b end=%0d expected full=%b rec=0 end=%0d", full, recording, end_addr, m_full, m_end);
        end
        do_start();
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (full !== 1'b0) begin
            errors++; $display("FAIL full_clear: got %b expected 0", full);
        end
        do_stop();
    endtask

    task automatic test_peak();
        logic [15:0] samples [3];
        samples[0] = 16'h0100; samples[1] = 16'hF000; samples[2] = 16'h8000;
        do_start();
        for (int i = 0; i < 3; i++) begin
            send_frame(samples[i], 16'($urandom), -1, -1, -1);
`ifdef AUD_REC_PEAK_EN
            checks++;
            if (peak !== 16'(m_peak)) begin
                errors++; $display("FAIL peak%0d: got %h expected %h", i, peak, 16'(m_peak));
            end
`endif
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL peak_count: got %0d writes expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL peak_write%0d: got %h/%h expected %h/%h", i, obs_q[i].addr, obs_q[i].data, exp_q[i].addr, exp_q[i].data);
            end
        end
        do_stop();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_right_channel();
        test_pause();
        test_stop();
        test_full();
        test_peak();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
